// File: rtl/ls161_timer_pkg.sv
// ls161_timer_pkg: shared states and constants for the LS161 interval-timer controller
package ls161_timer_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, EXPIRE} state_t;
  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;
  localparam logic [3:0] TERM_CNT = 4'hF;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: emits one tick every P+1 enabled clocks
module tick_prescaler #(
  parameter int PRE_W = 8
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             clear,
  input  logic             enable,
  input  logic [PRE_W-1:0] P,
  output logic             tick
);
  logic [PRE_W-1:0] cnt;
  assign tick = enable & (cnt == P);
  always_ff @(posedge CLK or posedge CLR)
    if (CLR) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/ls161_timer_ctrl.sv
// ls161_timer_ctrl: command-driven interval timer sequencing an external LS161 counter
module ls161_timer_ctrl
  import ls161_timer_pkg::*;
#(
  parameter int PRE_W = 8
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic             CMD_MODE,
  input  logic [3:0]       CMD_COUNT,
  input  logic [PRE_W-1:0] CMD_PRESCALE,
  input  logic             ABORT,
  output logic             DONE,
  output logic             BUSY,
  input  logic [3:0]       CNT_Q,
  input  logic             CNT_RCO,
  output logic [3:0]       CNT_D,
  output logic             CNT_LOAD_n,
  output logic             CNT_ENP,
  output logic             CNT_ENT,
  output logic             CNT_CLR_n
);
  state_t state, state_nxt;
  logic mode_r;
  logic [3:0] n_r;
  logic [PRE_W-1:0] p_r;
  logic tick, accept, run;
  assign CMD_READY = (state == IDLE) & ~ABORT;
  assign accept = CMD_VALID & CMD_READY;
  assign CNT_CLR_n = ~CLR;
  always_ff @(posedge CLK or posedge CLR)
    if (CLR) begin
      state <= IDLE;
      mode_r <= MODE_ONESHOT;
      n_r <= 4'h0;
      p_r <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mode_r <= CMD_MODE;
        n_r <= CMD_COUNT;
        p_r <= CMD_PRESCALE;
      end
    end
  tick_prescaler #(.PRE_W(PRE_W)) u_pre (
    .CLK(CLK),
    .CLR(CLR),
    .clear(state == LOAD),
    .enable(state == RUN),
    .P(p_r),
    .tick(tick)
  );
  // ENT only in RUN keeps RCO low on the first RUN cycle; ABORT wins over RCO
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = accept ? LOAD : IDLE;
      LOAD: state_nxt = ABORT ? IDLE : RUN;
      RUN: state_nxt = ABORT ? IDLE : (CNT_RCO ? EXPIRE : RUN);
      EXPIRE: state_nxt = (~ABORT & (mode_r == MODE_PERIODIC)) ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
    run = (state == RUN) & ~ABORT;
    DONE = state == EXPIRE;
    BUSY = state != IDLE;
    CNT_LOAD_n = state != LOAD;
    CNT_D = (state == LOAD) ? ~n_r : 4'h0;
    CNT_ENT = run;
    CNT_ENP = run & tick & (CNT_Q != TERM_CNT);
  end
endmodule

// File: tb/tb_ls161_timer_ctrl.sv
// tb_ls161_timer_ctrl: LS161 counter model plus timing-formula reference with per-cycle compare
module tb_ls161_timer_ctrl;
  localparam int PRE_W = 8;
  logic CLK = 0, CLR = 1;
  logic CMD_VALID = 0, CMD_MODE = 0, ABORT = 0;
  logic [3:0] CMD_COUNT = 0;
  logic [PRE_W-1:0] CMD_PRESCALE = 0;
  logic CMD_READY, DONE, BUSY, CNT_LOAD_n, CNT_ENP, CNT_ENT, CNT_CLR_n;
  logic [3:0] CNT_D;
  logic [3:0] q = 0;
  logic rco = 0;
  int vecs = 0, miss = 0;
  int ph = 0, k = 0, m = 0, n = 0, p = 0;
  int c;
  always #5 CLK = ~CLK;
  ls161_timer_ctrl #(.PRE_W(PRE_W)) dut (
    .CLK(CLK), .CLR(CLR), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_MODE(CMD_MODE), .CMD_COUNT(CMD_COUNT), .CMD_PRESCALE(CMD_PRESCALE),
    .ABORT(ABORT), .DONE(DONE), .BUSY(BUSY), .CNT_Q(q), .CNT_RCO(rco),
    .CNT_D(CNT_D), .CNT_LOAD_n(CNT_LOAD_n), .CNT_ENP(CNT_ENP),
    .CNT_ENT(CNT_ENT), .CNT_CLR_n(CNT_CLR_n)
  );
  task automatic chk(input string nm, input int a, input int e);
    vecs++;
    if (a != e) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, a, e, $time);
    end
  endtask
  // external LS161 with registered RCO
  always @(posedge CLK or negedge CNT_CLR_n)
    if (!CNT_CLR_n) begin
      q <= 4'h0;
      rco <= 1'b0;
    end else begin
      rco <= CNT_ENT & (q == 4'hF);
      if (!CNT_LOAD_n) q <= CNT_D;
      else if (CNT_ENP & CNT_ENT) q <= q + 4'd1;
    end
  // reference: phase 0 idle, 1 load, 2 run (k = RUN index), 3 expire
  always @(posedge CLK or posedge CLR)
    if (CLR) begin
      ph <= 0; k <= 0; m <= 0; n <= 0; p <= 0;
    end else
      case (ph)
        0: if (CMD_VALID && !ABORT) begin
             ph <= 1; m <= int'(CMD_MODE); n <= int'(CMD_COUNT); p <= int'(CMD_PRESCALE);
           end
        1: begin ph <= ABORT ? 0 : 2; k <= 0; end
        2: if (ABORT) ph <= 0;
           else if (k == n * (p + 1) + 1) ph <= 3;
           else k <= k + 1;
        default: ph <= (!ABORT && m == 1) ? 1 : 0;
      endcase
  always @(negedge CLK) begin
    chk("busy", int'(BUSY), int'(ph != 0));
    chk("ready", int'(CMD_READY), int'(ph == 0 && !ABORT));
    chk("done", int'(DONE), int'(ph == 3));
    chk("load_n", int'(CNT_LOAD_n), int'(ph != 1));
    chk("cnt_d", int'(CNT_D), ph == 1 ? 15 - n : 0);
    chk("ent", int'(CNT_ENT), int'(ph == 2 && !ABORT));
    chk("enp", int'(CNT_ENP), int'(ph == 2 && !ABORT && k < n * (p + 1) && (k + 1) % (p + 1) == 0));
    chk("clr_n", int'(CNT_CLR_n), int'(!CLR));
    if (ph == 2) chk("q", int'(q), 15 - n + ((k / (p + 1)) < n ? k / (p + 1) : n));
  end
  task automatic issue(input logic md, input logic [3:0] cnt, input logic [PRE_W-1:0] pre);
    @(posedge CLK); #1;
    CMD_VALID = 1; CMD_MODE = md; CMD_COUNT = cnt; CMD_PRESCALE = pre;
    @(posedge CLK); #1;
    CMD_VALID = 0;
  endtask
  task automatic run_until_done(input int exp_d, output int cyc);
    bit got = 0;
    cyc = 1;
    while (!got && cyc < 400) begin
      @(negedge CLK);
      if (cyc == 1) chk("load_d", int'(CNT_D), exp_d);
      if (DONE) got = 1;
      else begin
        @(posedge CLK); #1;
        cyc++;
      end
    end
    if (!got) chk("done_timeout", 0, 1);
  endtask
  initial begin
    int dn;
    bit hit;
    @(negedge CLK);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_done", int'(DONE), 0);
    chk("rst_load_n", int'(CNT_LOAD_n), 1);
    chk("rst_d", int'(CNT_D), 0);
    chk("rst_ent", int'(CNT_ENT), 0);
    chk("rst_enp", int'(CNT_ENP), 0);
    @(posedge CLK); #1 CLR = 0;
    issue(0, 3, 0);
    run_until_done(12, c);
    chk("n3p0_cycle", c, 7);
    chk("n3p0_q", int'(q), 15);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("n3p0_idle", int'(BUSY), 0);
    chk("n3p0_ready", int'(CMD_READY), 1);
    issue(1, 2, 1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(posedge CLK); #1; end
      run_until_done(13, c);
      chk("periodic_spacing", c, 8);
    end
    repeat (3) begin @(posedge CLK); #1; end
    ABORT = 1;
    @(posedge CLK); #1 ABORT = 0;
    dn = 0;
    repeat (20) begin @(negedge CLK); dn += int'(DONE); end
    chk("abort_no_done", dn, 0);
    chk("abort_idle", int'(BUSY), 0);
    issue(0, 0, 5);
    run_until_done(15, c);
    chk("n0_cycle", c, 4);
    issue(0, 15, 0);
    run_until_done(0, c);
    chk("n15_cycle", c, 19);
    chk("n15_q", int'(q), 15);
    issue(0, 1, 0);
    repeat (3) begin @(posedge CLK); #1; end
    ABORT = 1;
    @(negedge CLK);
    chk("race_rco", int'(rco), 1);
    chk("race_done", int'(DONE), 0);
    @(posedge CLK); #1 ABORT = 0;
    @(negedge CLK);
    chk("race_idle", int'(BUSY), 0);
    chk("race_no_done", int'(DONE), 0);
    @(posedge CLK); #1;
    CMD_VALID = 1; ABORT = 1;
    @(negedge CLK);
    chk("abort_ready", int'(CMD_READY), 0);
    @(posedge CLK); #1 CMD_VALID = 0; ABORT = 0;
    @(negedge CLK);
    chk("abort_no_accept", int'(BUSY), 0);
    issue(0, 15, 3);
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge CLK);
      hit = BUSY && q == 4'd7;
    end
    chk("clr_reach_q7", int'(hit), 1);
    #1 CLR = 1;
    #1;
    chk("clr_busy", int'(BUSY), 0);
    chk("clr_clr_n", int'(CNT_CLR_n), 0);
    chk("clr_ent", int'(CNT_ENT), 0);
    chk("clr_enp", int'(CNT_ENP), 0);
    @(posedge CLK); #1 CLR = 0;
    issue(0, 2, 0);
    run_until_done(13, c);
    chk("after_clr_cycle", c, 6);
    for (int i = 0; i < 3000; i++) begin
      @(posedge CLK); #1;
      CMD_VALID = ($urandom % 3) == 0;
      CMD_MODE = 1'($urandom % 2);
      CMD_COUNT = 4'($urandom % 16);
      CMD_PRESCALE = ($urandom % 8 == 0) ? PRE_W'($urandom % 16) : PRE_W'($urandom % 4);
      ABORT = ($urandom % 25) == 0;
    end
    @(posedge CLK); #1 CMD_VALID = 0; ABORT = 0;
    repeat (3) @(posedge CLK);
    #1 $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
